// File: rtl/exec_time_counter.sv
// exec_time_counter: measures how long the processor stays in the execution
// phase, latches the result for the seven-segment path and issues one
// conversion start pulse per run once the controller reaches finish.
// Optional build macro EXEC_TIMER_US_EN: count whole microseconds through a
// CLK_PER_US prescaler instead of raw clock cycles.
module exec_time_counter #(
    parameter int unsigned CLK_PER_US = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state,
    input  logic        conv_ready,
    output logic [25:0] binary_time_value,
    output logic        start_timeValue_convetion,
    output logic        running,
    output logic        overflow
);

    localparam int unsigned CNT_W = 26;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        WAIT_FIN = 2'd2,
        DONE     = 2'd3
    } fsm_t;

    // Elaboration-time guard on the prescaler range
    if (CLK_PER_US < 2 || CLK_PER_US > 1023) begin : g_param_check
        $error("exec_time_counter: CLK_PER_US out of range 2..1023");
    end

`ifdef EXEC_TIMER_US_EN
    localparam int unsigned PRESC_W = 10;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_US - 1);
    localparam logic [CNT_W-1:0]   CNT_START  = '0;

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_nx;
    logic               tick;
`else
    localparam logic [CNT_W-1:0]   CNT_START  = CNT_W'(1);
`endif

    fsm_t             fsm_q;
    fsm_t             fsm_nx;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] btv_nx;
    logic             start_nx;
    logic             ovf_nx;
    logic             begin_run;

    // Next-state, counter and output computation
    always_comb begin
        fsm_nx    = fsm_q;
        cnt_nx    = cnt_q;
        btv_nx    = binary_time_value;
        start_nx  = 1'b0;
        ovf_nx    = overflow;
        begin_run = 1'b0;
`ifdef EXEC_TIMER_US_EN
        presc_nx  = presc_q;
        tick      = (presc_q == PRESC_LAST);
`endif

        case (fsm_q)
            IDLE: begin
                if (state == ST_EXEC) begin
                    begin_run = 1'b1;
                end
            end
            COUNT: begin
                if (state == ST_EXEC) begin
`ifdef EXEC_TIMER_US_EN
                    presc_nx = tick ? '0 : presc_q + PRESC_W'(1);
                    if (tick) begin
                        if (cnt_q == CNT_MAX) begin
                            ovf_nx = 1'b1;
                        end else begin
                            cnt_nx = cnt_q + CNT_W'(1);
                        end
                    end
`else
                    if (cnt_q == CNT_MAX) begin
                        ovf_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt_q + CNT_W'(1);
                    end
`endif
                end else begin
                    btv_nx = cnt_q;
                    fsm_nx = WAIT_FIN;
                end
            end
            WAIT_FIN: begin
                if (state == ST_FINISH) begin
                    if (conv_ready) begin
                        start_nx = 1'b1;
                        fsm_nx   = DONE;
                    end
                end else if (state == ST_EXEC) begin
                    begin_run = 1'b1;
                end else if (state == ST_IDLE) begin
                    fsm_nx = IDLE;
                end
            end
            DONE: begin
                if (state == ST_EXEC) begin
                    begin_run = 1'b1;
                end else if (state == ST_IDLE) begin
                    fsm_nx = IDLE;
                end
            end
            default: fsm_nx = IDLE;
        endcase

        // A new run clears the sticky overflow and restarts the count
        if (begin_run) begin
            fsm_nx = COUNT;
            cnt_nx = CNT_START;
            ovf_nx = 1'b0;
`ifdef EXEC_TIMER_US_EN
            presc_nx = '0;
`endif
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q                     <= IDLE;
            cnt_q                     <= '0;
            binary_time_value         <= '0;
            start_timeValue_convetion <= 1'b0;
            running                   <= 1'b0;
            overflow                  <= 1'b0;
`ifdef EXEC_TIMER_US_EN
            presc_q                   <= '0;
`endif
        end else begin
            fsm_q                     <= fsm_nx;
            cnt_q                     <= cnt_nx;
            binary_time_value         <= btv_nx;
            start_timeValue_convetion <= start_nx;
            running                   <= (fsm_nx == COUNT);
            overflow                  <= ovf_nx;
`ifdef EXEC_TIMER_US_EN
            presc_q                   <= presc_nx;
`endif
        end
    end

endmodule

// File: tb/tb_exec_time_counter.sv
// Scoreboard bench for exec_time_counter: stimulus pushes the value expected
// with each start pulse; a monitor pops and compares whenever a pulse appears.
module tb_exec_time_counter;

    logic        clk;
    logic        rst;
    logic [2:0]  state;
    logic        conv_ready;
    logic [25:0] binary_time_value;
    logic        start_timeValue_convetion;
    logic        running;
    logic        overflow;

    int tests;
    int failed;
    int pulse_cnt;
    int run_cycles;
    int p0;
    int r0;
    logic [25:0] exp_q[$];

    exec_time_counter #(.CLK_PER_US(50)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .state                     (state),
        .conv_ready                (conv_ready),
        .binary_time_value         (binary_time_value),
        .start_timeValue_convetion (start_timeValue_convetion),
        .running                   (running),
        .overflow                  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    task automatic cyc(input logic [2:0] s, input logic cr, input int n);
        state      = s;
        conv_ready = cr;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every start pulse must carry the next expected latched value
    always @(negedge clk) begin
        if (start_timeValue_convetion === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_pulse: got value %0d, expected no pulse", binary_time_value);
            end else begin
                chk("pulse_value", 32'(binary_time_value), 32'(exp_q.pop_front()));
            end
        end
        if (running === 1'b1) run_cycles++;
    end

    initial begin
        tests      = 0;
        failed     = 0;
        pulse_cnt  = 0;
        run_cycles = 0;
        rst        = 1'b1;
        state      = 3'd0;
        conv_ready = 1'b0;
        cyc(3'd0, 1'b0, 3);
        chk("reset_btv", 32'(binary_time_value), 0);
        chk("reset_start", 32'(start_timeValue_convetion), 0);
        chk("reset_running", 32'(running), 0);
        chk("reset_overflow", 32'(overflow), 0);
        rst = 1'b0;

`ifdef EXEC_TIMER_US_EN
        p0 = pulse_cnt;
        exp_q.push_back(26'd5);
        cyc(3'd4, 1'b1, 275);
        cyc(3'd5, 1'b1, 1);
        chk("us_latch_275", 32'(binary_time_value), 5);
        cyc(3'd6, 1'b1, 3);
        cyc(3'd0, 1'b1, 2);
        exp_q.push_back(26'd1);
        cyc(3'd4, 1'b1, 51);
        cyc(3'd6, 1'b1, 1);
        chk("us_latch_51", 32'(binary_time_value), 1);
        cyc(3'd6, 1'b1, 3);
        chk("us_pulse_count", 32'(pulse_cnt - p0), 2);
`else
        // Basic run: 100 cycles of execute, then transmit, then finish
        p0 = pulse_cnt;
        r0 = run_cycles;
        exp_q.push_back(26'd100);
        cyc(3'd3, 1'b1, 2);
        cyc(3'd4, 1'b1, 100);
        chk("basic_running_mid", 32'(running), 1);
        cyc(3'd5, 1'b1, 1);
        chk("basic_latch", 32'(binary_time_value), 100);
        chk("basic_running_off", 32'(running), 0);
        cyc(3'd5, 1'b1, 9);
        chk("basic_no_early_pulse", 32'(pulse_cnt - p0), 0);
        cyc(3'd6, 1'b1, 1);
        chk("basic_pulse_timing", 32'(start_timeValue_convetion), 1);
        cyc(3'd6, 1'b1, 1);
        chk("basic_pulse_width", 32'(start_timeValue_convetion), 0);
        cyc(3'd6, 1'b1, 5);
        chk("basic_pulse_count", 32'(pulse_cnt - p0), 1);
        chk("basic_running_cycles", 32'(run_cycles - r0), 100);

        // Deferred start while the converter is busy
        cyc(3'd0, 1'b1, 2);
        p0 = pulse_cnt;
        exp_q.push_back(26'd30);
        cyc(3'd4, 1'b1, 30);
        cyc(3'd5, 1'b1, 2);
        cyc(3'd6, 1'b0, 5);
        chk("deferred_no_pulse", 32'(pulse_cnt - p0), 0);
        chk("deferred_start_low", 32'(start_timeValue_convetion), 0);
        cyc(3'd6, 1'b1, 1);
        chk("deferred_pulse", 32'(start_timeValue_convetion), 1);
        cyc(3'd6, 1'b1, 3);
        cyc(3'd6, 1'b0, 2);
        cyc(3'd6, 1'b1, 2);
        chk("deferred_single_pulse", 32'(pulse_cnt - p0), 1);

        // Saturation from a preloaded count
        cyc(3'd0, 1'b1, 2);
        exp_q.push_back(26'h3FFFFFF);
        cyc(3'd4, 1'b1, 2);
        force dut.cnt_q = 26'h3FFFFFE;
        #1;
        release dut.cnt_q;
        cyc(3'd4, 1'b1, 5);
        chk("sat_overflow_set", 32'(overflow), 1);
        cyc(3'd5, 1'b1, 1);
        chk("sat_latch", 32'(binary_time_value), 32'h03FF_FFFF);
        cyc(3'd6, 1'b1, 3);
        cyc(3'd0, 1'b1, 2);
        chk("sat_overflow_sticky", 32'(overflow), 1);
        cyc(3'd4, 1'b1, 1);
        chk("sat_overflow_cleared", 32'(overflow), 0);

        // Execute to idle: value latched, no pulse
        cyc(3'd4, 1'b1, 2);
        p0 = pulse_cnt;
        cyc(3'd0, 1'b1, 1);
        chk("abort_latch", 32'(binary_time_value), 3);
        cyc(3'd0, 1'b1, 3);
        cyc(3'd6, 1'b1, 3);
        chk("abort_no_pulse", 32'(pulse_cnt - p0), 0);

        // Reset in the middle of a run
        cyc(3'd0, 1'b1, 1);
        p0 = pulse_cnt;
        cyc(3'd4, 1'b1, 40);
        chk("rst_mid_running", 32'(running), 1);
        rst = 1'b1;
        cyc(3'd4, 1'b1, 1);
        rst = 1'b0;
        chk("rst_mid_btv", 32'(binary_time_value), 0);
        chk("rst_mid_running_off", 32'(running), 0);
        chk("rst_mid_start", 32'(start_timeValue_convetion), 0);
        cyc(3'd5, 1'b1, 2);
        cyc(3'd6, 1'b1, 3);
        chk("rst_mid_no_pulse", 32'(pulse_cnt - p0), 0);

        // Back-to-back runs, first one going straight from execute to finish
        cyc(3'd0, 1'b1, 1);
        p0 = pulse_cnt;
        exp_q.push_back(26'd20);
        cyc(3'd4, 1'b1, 20);
        cyc(3'd6, 1'b1, 1);
        chk("b2b_latch1", 32'(binary_time_value), 20);
        chk("b2b_start_not_same_edge", 32'(start_timeValue_convetion), 0);
        cyc(3'd6, 1'b1, 1);
        chk("b2b_pulse1", 32'(start_timeValue_convetion), 1);
        cyc(3'd6, 1'b1, 1);
        cyc(3'd0, 1'b1, 2);
        exp_q.push_back(26'd7);
        cyc(3'd4, 1'b1, 7);
        cyc(3'd5, 1'b1, 1);
        chk("b2b_latch2", 32'(binary_time_value), 7);
        cyc(3'd6, 1'b1, 3);
        cyc(3'd0, 1'b1, 2);
        chk("b2b_pulse_count", 32'(pulse_cnt - p0), 2);
`endif

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
